// File: rtl/addsub_accn.sv
// Signed N-bit adder/subtractor with an accumulator, optional saturation and
// overflow flags, behind a valid-qualified two-stage register pipeline.
module addsub_accn #(
  parameter int N        = 8,
  parameter int SATURATE = 0,
  parameter int CW       = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          In_Valid,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic          Sub,
  input  logic          Mode,
  input  logic          Clear,
  output logic [N-1:0]  S,
  output logic          Out_Valid,
  output logic          Overflow,
  output logic          Ovf_Sticky,
  output logic [CW-1:0] Op_Count
);

  // Handshake: no back-pressure. In_Valid high at edge k captures the op; Out_Valid
  // pulses for exactly one cycle after edge k+1 with S/Overflow for that op.

  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic          sub_q, sub_d, mode_q, mode_d, v1_q, v1_d;
  logic [N-1:0]  acc_q, acc_d, s_q, s_d;
  logic          ovf_q, ovf_d, sticky_q, sticky_d, ov_q, ov_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  acc_eff, x, r;
  logic [N:0]    x_ext, b_ext, y_ext, r_ext;
  logic          ovf;
  logic          sticky_base;
  logic [CW-1:0] cnt_base, cnt_inc;

  always_comb begin
    acc_eff = Clear ? '0 : acc_q;
    x       = mode_q ? acc_eff : a_q;
    x_ext   = {x[N-1], x};
    b_ext   = {b_q[N-1], b_q};
    // Negating at N+1 bits keeps -min exact, so the sum never leaves the range.
    y_ext   = sub_q ? ((~b_ext) + {{N{1'b0}}, 1'b1}) : b_ext;
    r_ext   = x_ext + y_ext;
    ovf     = r_ext[N] ^ r_ext[N-1];
    r       = r_ext[N-1:0];
    if ((SATURATE != 0) && ovf) begin
      r = r_ext[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
    sticky_base = Clear ? 1'b0 : sticky_q;
    cnt_base    = Clear ? '0 : cnt_q;
    cnt_inc     = (&cnt_base) ? cnt_base : cnt_base + CW'(1);
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    mode_d   = mode_q;
    v1_d     = In_Valid;
    acc_d    = acc_q;
    s_d      = s_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    ov_d     = 1'b0;
    if (In_Valid) begin
      a_d    = A;
      b_d    = B;
      sub_d  = Sub;
      mode_d = Mode;
    end
    if (v1_q) begin
      s_d      = r;
      ovf_d    = ovf;
      acc_d    = r;
      ov_d     = 1'b1;
      cnt_d    = cnt_inc;
      sticky_d = sticky_base | ovf;
    end else if (Clear) begin
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      mode_q   <= 1'b0;
      v1_q     <= 1'b0;
      acc_q    <= '0;
      s_q      <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      mode_q   <= mode_d;
      v1_q     <= v1_d;
      acc_q    <= acc_d;
      s_q      <= s_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
    end
  end

  assign S          = s_q;
  assign Out_Valid  = ov_q;
  assign Overflow   = ovf_q;
  assign Ovf_Sticky = sticky_q;
  assign Op_Count   = cnt_q;

endmodule

// File: tb/tb_addsub_accn.sv
// Bench for addsub_accn: three configurations (wrap, saturate, 2-bit counter) share
// one stimulus stream and are compared every cycle against an integer model.
module tb_addsub_accn;

  logic       clk;
  logic       rst, iv, sub, mode, clr;
  logic [7:0] a, b;

  logic [7:0] d_s[3];
  logic       d_ov[3], d_ovf[3], d_st[3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [7:0] d_cnt[3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  addsub_accn #(.N(8), .SATURATE(0), .CW(8)) dut_wrap (
    .Clock(clk), .Reset(rst), .In_Valid(iv), .A(a), .B(b), .Sub(sub), .Mode(mode),
    .Clear(clr), .S(d_s[0]), .Out_Valid(d_ov[0]), .Overflow(d_ovf[0]),
    .Ovf_Sticky(d_st[0]), .Op_Count(cnt0));
  addsub_accn #(.N(8), .SATURATE(1), .CW(8)) dut_sat (
    .Clock(clk), .Reset(rst), .In_Valid(iv), .A(a), .B(b), .Sub(sub), .Mode(mode),
    .Clear(clr), .S(d_s[1]), .Out_Valid(d_ov[1]), .Overflow(d_ovf[1]),
    .Ovf_Sticky(d_st[1]), .Op_Count(cnt1));
  addsub_accn #(.N(8), .SATURATE(0), .CW(2)) dut_cw2 (
    .Clock(clk), .Reset(rst), .In_Valid(iv), .A(a), .B(b), .Sub(sub), .Mode(mode),
    .Clear(clr), .S(d_s[2]), .Out_Valid(d_ov[2]), .Overflow(d_ovf[2]),
    .Ovf_Sticky(d_st[2]), .Op_Count(cnt2));

  always_comb begin
    d_cnt[0] = cnt0;
    d_cnt[1] = cnt1;
    d_cnt[2] = {6'b0, cnt2};
  end

  task automatic check(input string name, input int cfg, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, cfg, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model (integer arithmetic) ----------------
  bit model_ready = 0;
  int m_s[3], m_acc[3], m_ovf[3], m_st[3], m_cnt[3], m_ov[3];
  int p_v, p_a, p_b, p_sub, p_mode;

  function automatic int cnt_max(input int c);
    return (c == 2) ? 3 : 255;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_ready = 1;
      for (int c = 0; c < 3; c++) begin
        m_s[c] = 0; m_acc[c] = 0; m_ovf[c] = 0; m_st[c] = 0; m_cnt[c] = 0; m_ov[c] = 0;
      end
      p_v = 0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        int x, t, r, o;
        if (p_v != 0) begin
          x = (p_mode != 0) ? (clr ? 0 : m_acc[c]) : p_a;
          t = (p_sub != 0) ? x - p_b : x + p_b;
          o = (t > 127 || t < -128) ? 1 : 0;
          if (o != 0 && c == 1) r = (t < 0) ? -128 : 127;
          else begin
            r = t & 255;
            if (r > 127) r -= 256;
          end
          m_acc[c] = r;
          m_s[c]   = r & 255;
          m_ovf[c] = o;
          m_st[c]  = (clr ? 0 : m_st[c]) | o;
          m_cnt[c] = (clr ? 0 : m_cnt[c]) + 1;
          if (m_cnt[c] > cnt_max(c)) m_cnt[c] = cnt_max(c);
          m_ov[c]  = 1;
        end else begin
          m_ov[c] = 0;
          if (clr) begin
            m_acc[c] = 0; m_cnt[c] = 0; m_st[c] = 0;
          end
        end
      end
      p_v = iv ? 1 : 0;
      if (iv) begin
        p_a = $signed(a); p_b = $signed(b); p_sub = sub ? 1 : 0; p_mode = mode ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      for (int c = 0; c < 3; c++) begin
        check("out_valid", c, int'(d_ov[c]), m_ov[c]);
        check("s", c, int'(d_s[c]), m_s[c]);
        check("overflow", c, int'(d_ovf[c]), m_ovf[c]);
        check("sticky", c, int'(d_st[c]), m_st[c]);
        check("op_count", c, int'(d_cnt[c]), m_cnt[c]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv,
                      input logic sv, input logic mv, input logic cv, input logic rv);
    iv = v; a = av; b = bv; sub = sv; mode = mv; clr = cv; rst = rv;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic cv);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, cv, 1'b0);
  endtask

  logic [7:0] t2_a[3] = '{8'h80, 8'h00, 8'h05};
  logic [7:0] t2_b[3] = '{8'h01, 8'h80, 8'h03};
  logic [7:0] t2_s[3] = '{8'h80, 8'h7F, 8'h02};
  int         t2_o[3] = '{1, 1, 0};

  initial begin
    iv = 0; a = 0; b = 0; sub = 0; mode = 0; clr = 0; rst = 1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_s", 0, int'(d_s[0]), 0);
    check("reset_ov", 0, int'(d_ov[0]), 0);
    check("reset_cnt", 0, int'(d_cnt[0]), 0);

    // wrap-around overflow and one-cycle valid pulse
    step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("t1_s", 0, int'(d_s[0]), 8'h80);
    check("t1_ovf", 0, int'(d_ovf[0]), 1);
    check("t1_sticky", 0, int'(d_st[0]), 1);
    check("t1_valid", 0, int'(d_ov[0]), 1);
    check("t1_sat_s", 1, int'(d_s[1]), 8'h7F);
    idle(1'b0);
    check("t1_valid_drop", 0, int'(d_ov[0]), 0);

    // saturating corners
    for (int i = 0; i < 3; i++) begin
      step(1'b1, t2_a[i], t2_b[i], 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      check("t2_s", 1, int'(d_s[1]), int'(t2_s[i]));
      check("t2_ovf", 1, int'(d_ovf[1]), t2_o[i]);
    end

    // clear then back-to-back accumulate
    idle(1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h00, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i > 0) begin
        check("t3_s", 0, int'(d_s[0]), 16 * i);
        check("t3_valid", 0, int'(d_ov[0]), 1);
      end
    end
    idle(1'b0);
    check("t3_s_last", 0, int'(d_s[0]), 8'h50);
    check("t3_cnt", 0, int'(d_cnt[0]), 5);
    check("t3_sticky", 0, int'(d_st[0]), 0);

    // sticky survives clean ops; clear coincident with an accumulate
    step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("t4_ovf", 0, int'(d_ovf[0]), 0);
    check("t4_sticky", 0, int'(d_st[0]), 1);
    step(1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("t4_clr_s", 0, int'(d_s[0]), 1);
    check("t4_clr_cnt", 0, int'(d_cnt[0]), 1);
    check("t4_clr_sticky", 0, int'(d_st[0]), 0);

    // reset kills the op in flight
    step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_valid", 0, int'(d_ov[0]), 0);
    check("t5_s", 0, int'(d_s[0]), 0);
    check("t5_cnt", 0, int'(d_cnt[0]), 0);
    idle(1'b0);
    check("t5_valid_after", 0, int'(d_ov[0]), 0);
    step(1'b1, 8'h00, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check("t5_acc", 0, int'(d_s[0]), 3);

    // 2-bit op counter saturates
    idle(1'b1);
    for (int j = 1; j <= 5; j++) begin
      step(1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
      if (j > 1) check("t6_cnt", 2, int'(d_cnt[2]), (j - 1 > 3) ? 3 : j - 1);
    end
    idle(1'b0);
    check("t6_cnt_last", 2, int'(d_cnt[2]), 3);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0));
    end
    idle(1'b0);
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
